// File: rtl/si2c_target.sv
// si2c_target: I2C target byte engine. Filters SCL/SDA, detects START/STOP, matches a 7-bit
// address, ACKs written bytes and shifts out read bytes on an open-drain SDA (no clock stretching).
module si2c_target #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       i2c_scl_i,
  inout  wire        i2c_sda_io,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  output logic       tx_req_o,
  output logic       addr_match_o,
  output logic       rw_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_e;

  localparam logic [2:0] FILT_MAX = 3'(FILT_LEN - 1);

  // A filtered level only follows the sample after FILT_LEN consecutive differing samples.
  function automatic logic [3:0] filt_next(input logic smp, input logic lvl, input logic [2:0] cnt);
    logic [3:0] r;
    if (smp == lvl) begin
      r = {lvl, 3'd0};
    end else if (cnt == FILT_MAX) begin
      r = {smp, 3'd0};
    end else begin
      r = {lvl, cnt + 3'd1};
    end
    return r;
  endfunction

  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [2:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d, scl_p_q, scl_p_d, sda_p_q, sda_p_d;
  logic       scl_rise_s, scl_fall_s, start_s, stop_s;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d, tx_sh_q, tx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d, rw_q, rw_d, busy_q, busy_d, ack_clk_q, ack_clk_d;
  logic       rx_valid_q, rx_valid_d, tx_req_q, tx_req_d, addr_match_q, addr_match_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], i2c_scl_i};
    sda_sync_d = {sda_sync_q[0], i2c_sda_io};
    {scl_f_d, scl_cnt_d} = filt_next(scl_sync_q[1], scl_f_q, scl_cnt_q);
    {sda_f_d, sda_cnt_d} = filt_next(sda_sync_q[1], sda_f_q, sda_cnt_q);
    scl_p_d = scl_f_q;
    sda_p_d = sda_f_q;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_cnt_q  <= 3'd0;
      sda_cnt_q  <= 3'd0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_p_q    <= scl_p_d;
      sda_p_q    <= sda_p_d;
    end
  end

  // START/STOP need SCL stable high, so an SDA change coinciding with an SCL edge is data.
  assign scl_rise_s = scl_f_q & ~scl_p_q;
  assign scl_fall_s = ~scl_f_q & scl_p_q;
  assign start_s    = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_s     = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_s) begin
      state_d = S_ADDR;
    end else if (stop_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ADDR:     if (scl_rise_s && bit_cnt_q == 3'd7) state_d = (shift_q == SLAVE_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
                    else state_d = state_q;
        S_ADDR_ACK: if (scl_fall_s && ack_clk_q) state_d = rw_q ? S_RD_DATA : S_WR_DATA;
                    else state_d = state_q;
        S_WR_DATA:  if (scl_rise_s && bit_cnt_q == 3'd7) state_d = S_WR_ACK;
                    else state_d = state_q;
        S_WR_ACK:   if (scl_fall_s && ack_clk_q) state_d = S_WR_DATA;
                    else state_d = state_q;
        S_RD_DATA:  if (scl_fall_s && bit_cnt_q == 3'd7) state_d = S_RD_ACK;
                    else state_d = state_q;
        S_RD_ACK:   if (scl_rise_s && sda_f_q) state_d = S_WAIT_STOP;
                    else if (scl_fall_s && ack_clk_q) state_d = S_RD_DATA;
                    else state_d = state_q;
        default:    state_d = state_q;
      endcase
    end
  end

  // ack_clk marks that the ninth (ACK) SCL rise has been seen, so the next fall ends the ACK slot.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_sh_d      = tx_sh_q;
    rx_data_d    = rx_data_q;
    sda_oe_d     = sda_oe_q;
    rw_d         = rw_q;
    busy_d       = busy_q;
    ack_clk_d    = ack_clk_q;
    rx_valid_d   = 1'b0;
    tx_req_d     = 1'b0;
    addr_match_d = 1'b0;
    if (start_s) begin
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      ack_clk_d = 1'b0;
    end else if (stop_s) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise_s) begin
            shift_d   = {shift_q[5:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            ack_clk_d = 1'b0;
            if (bit_cnt_q == 3'd7 && shift_q == SLAVE_ADDR) begin
              addr_match_d = 1'b1;
              rw_d         = sda_f_q;
              busy_d       = 1'b1;
              tx_req_d     = sda_f_q;
            end else begin
              addr_match_d = 1'b0;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        S_ADDR_ACK, S_WR_ACK: begin
          if (scl_fall_s && ack_clk_q) begin
            bit_cnt_d = 3'd0;
            if (state_q == S_ADDR_ACK && rw_q) begin
              tx_sh_d  = tx_data_i[6:0];
              sda_oe_d = ~tx_data_i[7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end else if (scl_fall_s) begin
            sda_oe_d = 1'b1;
          end else if (scl_rise_s) begin
            ack_clk_d = 1'b1;
          end else begin
            ack_clk_d = ack_clk_q;
          end
        end
        S_WR_DATA: begin
          if (scl_rise_s) begin
            shift_d   = {shift_q[5:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            ack_clk_d = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = {shift_q, sda_f_q};
              rx_valid_d = 1'b1;
            end else begin
              rx_valid_d = 1'b0;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        S_RD_DATA: begin
          if (scl_fall_s && bit_cnt_q == 3'd7) begin
            sda_oe_d  = 1'b0;
            ack_clk_d = 1'b0;
          end else if (scl_fall_s) begin
            sda_oe_d  = ~tx_sh_q[6];
            tx_sh_d   = {tx_sh_q[5:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            tx_sh_d = tx_sh_q;
          end
        end
        S_RD_ACK: begin
          if (scl_rise_s && sda_f_q) begin
            busy_d = 1'b0;
          end else if (scl_rise_s) begin
            tx_req_d  = 1'b1;
            ack_clk_d = 1'b1;
          end else if (scl_fall_s && ack_clk_q) begin
            tx_sh_d   = tx_data_i[6:0];
            sda_oe_d  = ~tx_data_i[7];
            bit_cnt_d = 3'd0;
          end else begin
            tx_sh_d = tx_sh_q;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      tx_sh_q      <= 7'd0;
      rx_data_q    <= 8'h00;
      sda_oe_q     <= 1'b0;
      rw_q         <= 1'b0;
      busy_q       <= 1'b0;
      ack_clk_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      addr_match_q <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_sh_q      <= tx_sh_d;
      rx_data_q    <= rx_data_d;
      sda_oe_q     <= sda_oe_d;
      rw_q         <= rw_d;
      busy_q       <= busy_d;
      ack_clk_q    <= ack_clk_d;
      rx_valid_q   <= rx_valid_d;
      tx_req_q     <= tx_req_d;
      addr_match_q <= addr_match_d;
    end
  end

  assign i2c_sda_io   = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign tx_req_o     = tx_req_q;
  assign addr_match_o = addr_match_q;
  assign rw_o         = rw_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_si2c_target.sv
// tb_si2c_target: bus-master model driving si2c_target with table-driven transactions
// plus hand-written read, repeated-START, glitch and reset sequences.
module tb_si2c_target;
  localparam int Q = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, m_scl, m_sda;
  logic [7:0] tx_data, rx_data;
  logic       rx_valid, tx_req, addr_match, rw, busy;
  wire        sda_w;

  assign sda_w = m_sda ? 1'bz : 1'b0;
  pullup (sda_w);

  si2c_target #(.SLAVE_ADDR(7'h50), .FILT_LEN(3)) dut (
    .clk_i(clk), .rst_n(rst_n), .i2c_scl_i(m_scl), .i2c_sda_io(sda_w),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .tx_data_i(tx_data), .tx_req_o(tx_req),
    .addr_match_o(addr_match), .rw_o(rw), .busy_o(busy)
  );

  int   n_match = 0, n_rxv = 0, n_txreq = 0, n_drive = 0;
  logic last_rw = 1'b0;

  // Pulse counters and a detector for the target pulling SDA while the master releases it.
  always @(negedge clk) begin
    if (addr_match) begin
      n_match <= n_match + 1;
      last_rw <= rw;
    end
    if (rx_valid) n_rxv <= n_rxv + 1;
    if (tx_req) n_txreq <= n_txreq + 1;
    if (m_sda && sda_w === 1'b0) n_drive <= n_drive + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    m_sda = b;    wt(Q);
    m_scl = 1'b1; wt(Q);
    s = sda_w;    wt(Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wt(Q);
    m_scl = 1'b1; wt(Q);
    m_sda = 1'b0; wt(Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wt(Q);
    m_scl = 1'b1; wt(Q);
    m_sda = 1'b1; wt(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic [7:0] t;
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(1'b1, t[i]);
    bit_cycle(nack, s);
    d = t;
  endtask

  typedef struct {
    logic       is_rd;
    logic [7:0] addr;
    logic [7:0] data;
    logic       ack_a;
    logic       ack_d;
    int         match;
    int         txr;
    int         rxv;
    logic [7:0] rx;
    logic [7:0] rd;
  } vec_t;

  vec_t vt[7];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic       a, a2;
    logic [7:0] d, d2;
    int         m0, x0, t0, r0;

    vt[0] = '{1'b0, 8'hA0, 8'h3C, 1'b0, 1'b0, 1, 0, 1, 8'h3C, 8'hFF};
    vt[1] = '{1'b1, 8'hA1, 8'h96, 1'b0, 1'b1, 1, 1, 0, 8'h3C, 8'h96};
    vt[2] = '{1'b0, 8'hA2, 8'h55, 1'b1, 1'b1, 0, 0, 0, 8'h3C, 8'hFF};
    vt[3] = '{1'b0, 8'hA0, 8'hFF, 1'b0, 1'b0, 1, 0, 1, 8'hFF, 8'hFF};
    vt[4] = '{1'b1, 8'hA1, 8'h00, 1'b0, 1'b1, 1, 1, 0, 8'hFF, 8'h00};
    vt[5] = '{1'b1, 8'hA3, 8'h00, 1'b1, 1'b1, 0, 0, 0, 8'hFF, 8'hFF};
    vt[6] = '{1'b0, 8'hA0, 8'h00, 1'b0, 1'b0, 1, 0, 1, 8'h00, 8'hFF};

    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
    wt(3);
    chk("reset_outputs", 32'({rx_data, rx_valid, tx_req, addr_match, rw, busy}), 32'd0);
    chk("reset_sda", 32'(sda_w), 32'd1);
    rst_n = 1'b1;
    wt(Q);

    for (int i = 0; i < 7; i++) begin
      m0 = n_match; x0 = n_rxv; t0 = n_txreq; r0 = n_drive;
      tx_data = vt[i].data;
      i2c_start();
      write_byte(vt[i].addr, a);
      chk($sformatf("v%0d_addr_ack", i), 32'(a), 32'(vt[i].ack_a));
      if (vt[i].is_rd) begin
        read_byte(1'b1, d);
        chk($sformatf("v%0d_rd_data", i), 32'(d), 32'(vt[i].rd));
      end else begin
        write_byte(vt[i].data, a);
        chk($sformatf("v%0d_data_ack", i), 32'(a), 32'(vt[i].ack_d));
      end
      chk($sformatf("v%0d_busy_pre_stop", i), 32'(busy), 32'(vt[i].match == 1 && !vt[i].is_rd));
      i2c_stop();
      wt(Q);
      chk($sformatf("v%0d_busy_post_stop", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_match_cnt", i), 32'(n_match - m0), 32'(vt[i].match));
      chk($sformatf("v%0d_rxv_cnt", i), 32'(n_rxv - x0), 32'(vt[i].rxv));
      chk($sformatf("v%0d_txreq_cnt", i), 32'(n_txreq - t0), 32'(vt[i].txr));
      chk($sformatf("v%0d_rx_data", i), 32'(rx_data), 32'(vt[i].rx));
      if (vt[i].match != 0) chk($sformatf("v%0d_rw", i), 32'(last_rw), 32'(vt[i].is_rd));
      else chk($sformatf("v%0d_no_drive", i), 32'(n_drive - r0), 32'd0);
    end

    // Read with master ACK then NACK; afterwards the target must ignore further clocks.
    t0 = n_txreq;
    tx_data = 8'h96;
    i2c_start();
    write_byte(8'hA1, a);
    chk("rd2_addr_ack", 32'(a), 32'd0);
    tx_data = 8'h5A;
    read_byte(1'b0, d);
    read_byte(1'b1, d2);
    chk("rd2_byte0", 32'(d), 32'h96);
    chk("rd2_byte1", 32'(d2), 32'h5A);
    chk("rd2_txreq_cnt", 32'(n_txreq - t0), 32'd2);
    chk("rd2_busy_after_nack", 32'(busy), 32'd0);
    r0 = n_drive;
    read_byte(1'b1, d);
    chk("rd2_wait_stop_idle_bus", 32'(d), 32'hFF);
    chk("rd2_wait_stop_no_drive", 32'(n_drive - r0), 32'd0);
    i2c_stop();
    wt(Q);

    // Write then repeated START into a read.
    m0 = n_match;
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h01, a2);
    chk("rs_wr_acks", 32'({a, a2}), 32'd0);
    chk("rs_rx_data", 32'(rx_data), 32'h01);
    chk("rs_busy_mid", 32'(busy), 32'd1);
    tx_data = 8'h5A;
    i2c_start();
    write_byte(8'hA1, a);
    chk("rs_rd_addr_ack", 32'(a), 32'd0);
    chk("rs_match_cnt", 32'(n_match - m0), 32'd2);
    chk("rs_rw", 32'(last_rw), 32'd1);
    read_byte(1'b1, d);
    chk("rs_rd_data", 32'(d), 32'h5A);
    i2c_stop();
    wt(Q);

    // Glitches in IDLE: a clocked address without a real START must not be answered.
    m0 = n_match;
    m_sda = 1'b0; wt(1); m_sda = 1'b1; wt(Q);
    m_scl = 1'b0; wt(2); m_scl = 1'b1; wt(Q);
    chk("glitch_busy", 32'(busy), 32'd0);
    m_scl = 1'b0; wt(Q);
    write_byte(8'hA0, a);
    chk("glitch_no_ack", 32'(a), 32'd1);
    chk("glitch_no_match", 32'(n_match - m0), 32'd0);
    i2c_stop();
    wt(Q);

    // Reset while the target holds the address ACK low.
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_cycle(d[0] & 1'b0 | (i == 7 || i == 5), a);
    m_sda = 1'b1;
    #1;
    chk("rst_ack_driven", 32'(sda_w), 32'd0);
    chk("rst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_sda_released", 32'(sda_w), 32'd1);
    chk("rst_outputs_zero", 32'({rx_data, rx_valid, tx_req, addr_match, rw, busy}), 32'd0);
    wt(2);
    rst_n = 1'b1;
    m_scl = 1'b1; wt(Q);
    m_scl = 1'b0; wt(Q);
    i2c_stop();
    wt(Q);
    x0 = n_rxv;
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'hC3, a2);
    chk("post_rst_acks", 32'({a, a2}), 32'd0);
    i2c_stop();
    wt(Q);
    chk("post_rst_rx_data", 32'(rx_data), 32'hC3);
    chk("post_rst_rxv_cnt", 32'(n_rxv - x0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
